// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and widths for the kernel launch sequencer
package gpu_pkg;
    localparam int THREAD_COUNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        ABORT
    } launch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-bit level counter
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    // Ready depends only on stored level, so a full FIFO never accepts even if popping.
    assign wr_ready = (level != FULL_LVL);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_en && (level != '0);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/launch_queue.sv
// rtl/launch_queue.sv - buffers kernel launches and sequences them into the dispatch unit
module launch_queue
    import gpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_valid,
    output logic                        push_ready,
    input  logic [THREAD_COUNT_W-1:0]   push_thread_count,
    input  logic                        abort,
    output logic                        disp_reset,
    output logic                        disp_start,
    output logic [THREAD_COUNT_W-1:0]   disp_thread_count,
    input  logic                        disp_done,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      queue_level,
    output logic                        kernel_done,
    output logic                        kernel_aborted,
    output logic [CNT_W-1:0]            kernels_completed
);
    localparam int LW = $clog2(DEPTH) + 1;

    launch_state_t               state;
    launch_state_t               next_state;
    logic                        pop;
    logic                        push_fire;
    logic [THREAD_COUNT_W-1:0]   head;

    sync_fifo #(
        .WIDTH (THREAD_COUNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (push_valid),
        .wr_ready (push_ready),
        .wr_data  (push_thread_count),
        .rd_en    (pop),
        .rd_data  (head),
        .level    (queue_level)
    );

    assign push_fire = push_valid && push_ready;

    // The head is popped on the IDLE->LOAD edge so LOAD already sees its thread count.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (queue_level != '0) begin
                    next_state = LOAD;
                    pop        = 1'b1;
                end
            end
            LOAD:    next_state = (disp_thread_count == '0) ? DONE : RUN;
            RUN: begin
                if (abort) begin
                    next_state = ABORT;
                end else if (disp_done) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            disp_reset        <= 1'b1;
            disp_start        <= 1'b0;
            disp_thread_count <= '0;
            busy              <= 1'b0;
            kernel_done       <= 1'b0;
            kernel_aborted    <= 1'b0;
            kernels_completed <= '0;
        end else begin
            state          <= next_state;
            disp_reset     <= (next_state != RUN);
            disp_start     <= (next_state == RUN);
            kernel_done    <= (next_state == DONE) || (next_state == ABORT);
            kernel_aborted <= (next_state == ABORT);
            busy           <= (next_state != IDLE) || push_fire || (queue_level > LW'(pop));
            if (pop) begin
                disp_thread_count <= head;
            end
            if (next_state == DONE) begin
                kernels_completed <= kernels_completed + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_launch_queue.sv
// tb/tb_launch_queue.sv - scoreboard bench for launch_queue with a randomized dispatch model
module tb_launch_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             push_valid = 1'b0;
    logic             push_ready;
    logic [7:0]       push_thread_count = '0;
    logic             abort = 1'b0;
    logic             disp_reset;
    logic             disp_start;
    logic [7:0]       disp_thread_count;
    logic             disp_done = 1'b0;
    logic             busy;
    logic [LW-1:0]    queue_level;
    logic             kernel_done;
    logic             kernel_aborted;
    logic [CNT_W-1:0] kernels_completed;

    launch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .push_valid        (push_valid),
        .push_ready        (push_ready),
        .push_thread_count (push_thread_count),
        .abort             (abort),
        .disp_reset        (disp_reset),
        .disp_start        (disp_start),
        .disp_thread_count (disp_thread_count),
        .disp_done         (disp_done),
        .busy              (busy),
        .queue_level       (queue_level),
        .kernel_done       (kernel_done),
        .kernel_aborted    (kernel_aborted),
        .kernels_completed (kernels_completed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_tc_q[$];
    int act_q[$];
    int exp_ab_q[$];

    int mdl_delay = 1;
    int mdl_mode  = 0;
    bit mdl_noise = 1'b0;
    int model_done_cnt = 0;
    int starts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Dispatch model: per kernel, action 0=done, 1=abort, 2=abort together with done.
    int run_cyc = 0;
    int act = 0;
    int dly = 1;
    always @(negedge clk) begin
        if (!reset || !disp_start) begin
            run_cyc   = 0;
            disp_done = mdl_noise && reset && ($urandom_range(0, 3) == 0);
            abort     = mdl_noise && reset && ($urandom_range(0, 3) == 0);
        end else begin
            if (run_cyc == 0) begin
                if (act_q.size() != 0) act = act_q.pop_front();
                else if (mdl_mode == 3) act = int'($urandom_range(0, 2));
                else act = mdl_mode;
                dly = (mdl_delay != 0) ? mdl_delay : int'($urandom_range(1, 4));
                exp_ab_q.push_back((act != 0) ? 1 : 0);
            end
            run_cyc++;
            disp_done = 1'b0;
            abort     = 1'b0;
            if (run_cyc == dly) begin
                disp_done = (act != 1);
                abort     = (act != 0);
            end
        end
    end

    // Monitor: checks every start and every retirement against the scoreboard.
    bit prev_start = 1'b0;
    bit prev_reset = 1'b1;
    int exp_tc = 0;
    int exp_ab = 0;
    always @(negedge clk) begin
        if (reset) begin
            if (disp_start && !prev_start) begin
                starts++;
                check("start_after_disp_reset", prev_reset, 1);
                check("start_nonzero_count", disp_thread_count != 0, 1);
                if (exp_tc_q.size() == 0) check("start_unexpected", 1, 0);
                else check("start_thread_count", disp_thread_count, exp_tc_q[0]);
            end
            if (kernel_aborted && !kernel_done) check("aborted_without_done", 1, 0);
            if (kernel_done) begin
                if (exp_tc_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    exp_tc = exp_tc_q.pop_front();
                    exp_ab = 0;
                    if (exp_tc != 0) begin
                        if (exp_ab_q.size() == 0) check("abort_record_missing", 1, 0);
                        else exp_ab = exp_ab_q.pop_front();
                    end
                    if (exp_ab == 0) model_done_cnt++;
                    check("done_thread_count", disp_thread_count, exp_tc);
                    check("kernel_aborted", kernel_aborted, exp_ab);
                    check("kernels_completed", kernels_completed, model_done_cnt & 32'hFFFF);
                    check("done_disp_start", disp_start, 0);
                    check("done_disp_reset", disp_reset, 1);
                end
            end
        end
        prev_start = disp_start;
        prev_reset = disp_reset;
    end

    // Called just after a posedge; returns just after the posedge that transferred.
    task automatic push(input logic [7:0] tc);
        int t = 0;
        push_valid = 1'b1;
        push_thread_count = tc;
        while (!push_ready && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!push_ready) begin
            check("push_timeout", 1, 0);
            push_valid = 1'b0;
            return;
        end
        exp_tc_q.push_back(int'(tc));
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 3000 && (busy || exp_tc_q.size() != 0)) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) check("wait_idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    int base_cnt;
    int base_starts;
    int tc;
    int gap;
    int t;

    initial begin
        #12;
        check("rst_push_ready", push_ready, 1);
        check("rst_disp_reset", disp_reset, 1);
        check("rst_disp_start", disp_start, 0);
        check("rst_disp_thread_count", disp_thread_count, 0);
        check("rst_busy", busy, 0);
        check("rst_queue_level", queue_level, 0);
        check("rst_kernel_done", kernel_done, 0);
        check("rst_kernel_aborted", kernel_aborted, 0);
        check("rst_kernels_completed", kernels_completed, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single launch latency.
        mdl_delay = 1;
        mdl_mode  = 0;
        push(8'd10);
        check("lat_level_after_push", queue_level, 1);
        check("lat_busy_after_push", busy, 1);
        check("lat_start_after_push", disp_start, 0);
        @(posedge clk); #1;
        check("lat_load_count", disp_thread_count, 10);
        check("lat_load_start", disp_start, 0);
        check("lat_load_reset", disp_reset, 1);
        check("lat_load_level", queue_level, 0);
        @(posedge clk); #1;
        check("lat_run_start", disp_start, 1);
        check("lat_run_reset", disp_reset, 0);
        @(posedge clk); #1;
        check("lat_done_pulse", kernel_done, 1);
        check("lat_done_count", kernels_completed, 1);
        check("lat_done_start", disp_start, 0);
        @(posedge clk); #1;
        check("lat_pulse_one_cycle", kernel_done, 0);
        check("lat_idle_busy", busy, 0);

        // Back-to-back launches.
        mdl_delay = 0;
        push(8'd3);
        push(8'd5);
        push(8'd7);
        wait_idle();
        check("b2b_completed", kernels_completed, 4);
        check("b2b_starts", starts, 4);

        // Fill the queue while the first kernel runs long.
        mdl_delay = 40;
        push(8'd21);
        push(8'd22);
        push(8'd23);
        push(8'd24);
        push(8'd25);
        check("full_level", queue_level, DEPTH);
        check("full_ready_low", push_ready, 0);
        push(8'd26);
        check("full_level_after_refill", queue_level, DEPTH);
        wait_idle();
        mdl_delay = 0;

        // Zero-thread launch retires without starting dispatch.
        base_cnt    = model_done_cnt;
        base_starts = starts;
        push(8'd0);
        wait_idle();
        check("zero_completed", kernels_completed, (base_cnt + 1) & 32'hFFFF);
        check("zero_no_start", starts, base_starts);

        // Abort, abort coincident with done, then a normal kernel.
        base_cnt    = model_done_cnt;
        base_starts = starts;
        mdl_delay   = 2;
        act_q.push_back(1);
        act_q.push_back(2);
        act_q.push_back(0);
        push(8'd9);
        push(8'd11);
        push(8'd12);
        wait_idle();
        check("abort_completed", kernels_completed, (base_cnt + 1) & 32'hFFFF);
        check("abort_starts", starts, base_starts + 3);

        // Randomized traffic with stray abort/done outside RUN.
        mdl_delay = 0;
        mdl_mode  = 3;
        mdl_noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            push(tc[7:0]);
            gap = int'($urandom_range(0, 3));
            if (gap != 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        mdl_noise = 1'b0;
        mdl_mode  = 0;
        check("rand_completed", kernels_completed, model_done_cnt & 32'hFFFF);

        // Reset in the middle of a running kernel with launches queued.
        mdl_delay = 50;
        push(8'd30);
        push(8'd31);
        push(8'd32);
        t = 0;
        while (!disp_start && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("mid_rst_running", disp_start, 1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_start", disp_start, 0);
        check("mid_rst_disp_reset", disp_reset, 1);
        check("mid_rst_level", queue_level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_completed", kernels_completed, 0);
        exp_tc_q.delete();
        exp_ab_q.delete();
        act_q.delete();
        model_done_cnt = 0;
        base_starts    = starts;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_no_start", starts, base_starts);
        check("post_rst_start", disp_start, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_level", queue_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
